// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the instruction-memory read address
// and registers the returned word for decode, with stall and branch-redirect flush.
module instruction_fetch_unit #(
  parameter int              bus      = 32,
  parameter logic [bus-1:0]  RESET_PC = '0,
  parameter logic [bus-1:0]  NOP      = '0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           stall,
  input  logic           branch_taken,
  input  logic [bus-1:0] branch_target,
  output logic [bus-1:0] imem_addr,
  input  logic [bus-1:0] imem_data,
  output logic [bus-1:0] instr,
  output logic [bus-1:0] instr_pc,
  output logic           instr_valid,
  output logic           misaligned
);

  localparam logic [bus-1:0] PC_INIT = {RESET_PC[bus-1:2], 2'b00};
  localparam logic [bus-1:0] PC_STEP = bus'(4);

  logic [bus-1:0] pc_q, pc_d;
  logic [bus-1:0] instr_q, instr_d;
  logic [bus-1:0] instr_pc_q, instr_pc_d;
  logic           valid_q, valid_d;
  logic           mis_q, mis_d;

  // Branch beats stall; a redirect discards the word fetched from the old path.
  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    mis_d      = 1'b0;
    if (branch_taken) begin
      pc_d    = {branch_target[bus-1:2], 2'b00};
      instr_d = NOP;
      valid_d = 1'b0;
      mis_d   = |branch_target[1:0];
    end else if (!stall) begin
      instr_d    = imem_data;
      instr_pc_d = pc_q;
      valid_d    = 1'b1;
      pc_d       = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= PC_INIT;
      instr_q    <= NOP;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      mis_q      <= mis_d;
    end
  end

  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign misaligned  = mis_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit with a negedge-registered
// instruction memory model and an in-order scoreboard of expected fetches.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        misaligned;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] m_pc;
  int          n_cmp;
  int          n_err;

  instruction_fetch_unit #(
    .bus      (32),
    .RESET_PC (32'h0),
    .NOP      (32'h0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .misaligned    (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'hA000_0000 + (a >> 2);
  endfunction

  // Memory registers its read data on the falling edge.
  always @(negedge clk) imem_data <= word(imem_addr);

  // Apply one cycle of stimulus, record what a normal fetch should deliver,
  // then wait until just after the rising edge.
  task automatic drive(input logic br, input logic [31:0] tgt, input logic st);
    branch_taken  = br;
    branch_target = tgt;
    stall         = st;
    if (br) begin
      m_pc = {tgt[31:2], 2'b00};
    end else if (!st) begin
      sb.push_back('{instr: word(m_pc), pc: m_pc});
      m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
    branch_taken = 1'b0;
    stall        = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    #12;
    n_cmp++;
    if (imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr got=%h want=%h", imem_addr, 32'h0); end
    n_cmp++;
    if (instr_valid !== 1'b0 || misaligned !== 1'b0) begin
      n_err++; $display("FAIL reset_flags got valid=%b mis=%b want 0 0", instr_valid, misaligned);
    end
    n_cmp++;
    if (instr !== 32'h0 || instr_pc !== 32'h0) begin
      n_err++; $display("FAIL reset_data got instr=%h pc=%h want 0 0", instr, instr_pc);
    end
    reset = 1'b1;
    m_pc  = 32'h0;
    sb.delete();
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b0);
      n_cmp++;
      if (instr_valid !== 1'b1) begin n_err++; $display("FAIL seq_valid[%0d] got=%b want=1", i, instr_valid); end
      n_cmp++;
      if (imem_addr !== m_pc) begin n_err++; $display("FAIL seq_addr[%0d] got=%h want=%h", i, imem_addr, m_pc); end
      if (sb.size() == 0) begin
        n_cmp++; n_err++; $display("FAIL seq_sb_empty[%0d] got=empty want=entry", i);
      end else begin
        e = sb.pop_front();
        n_cmp++;
        if (instr !== e.instr || instr_pc !== e.pc) begin
          n_err++; $display("FAIL seq_data[%0d] got=%h@%h want=%h@%h", i, instr, instr_pc, e.instr, e.pc);
        end
      end
    end
    n_cmp++;
    if (instr !== 32'hA000_0002 || instr_pc !== 32'h8) begin
      n_err++; $display("FAIL seq_third got=%h@%h want=a0000002@00000008", instr, instr_pc);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'h0, 1'b1);
      n_cmp++;
      if (imem_addr !== 32'hC) begin n_err++; $display("FAIL stall_addr[%0d] got=%h want=0000000c", i, imem_addr); end
      n_cmp++;
      if (instr !== 32'hA000_0002 || instr_pc !== 32'h8 || instr_valid !== 1'b1) begin
        n_err++; $display("FAIL stall_hold[%0d] got=%h@%h v=%b want=a0000002@00000008 v=1", i, instr, instr_pc, instr_valid);
      end
    end
    drive(1'b0, 32'h0, 1'b0);
    if (sb.size() == 0) begin
      n_cmp++; n_err++; $display("FAIL stall_sb_empty got=empty want=entry");
    end else begin
      e = sb.pop_front();
      n_cmp++;
      if (instr !== e.instr || instr_pc !== e.pc || instr_valid !== 1'b1) begin
        n_err++; $display("FAIL stall_resume got=%h@%h want=%h@%h", instr, instr_pc, e.instr, e.pc);
      end
    end
    n_cmp++;
    if (instr !== 32'hA000_0003 || sb.size() != 0) begin
      n_err++; $display("FAIL stall_noskip got=%h pending=%0d want=a0000003 pending=0", instr, sb.size());
    end
  endtask

  task automatic test_branch();
    drive(1'b1, 32'h40, 1'b0);
    n_cmp++;
    if (instr_valid !== 1'b0 || imem_addr !== 32'h40 || misaligned !== 1'b0) begin
      n_err++; $display("FAIL br_bubble got v=%b addr=%h mis=%b want v=0 addr=00000040 mis=0", instr_valid, imem_addr, misaligned);
    end
    n_cmp++;
    if (instr !== 32'h0 || instr_pc !== 32'hC) begin
      n_err++; $display("FAIL br_flush got=%h@%h want=00000000@0000000c", instr, instr_pc);
    end
    drive(1'b0, 32'h0, 1'b0);
    if (sb.size() == 0) begin
      n_cmp++; n_err++; $display("FAIL br_sb_empty got=empty want=entry");
    end else begin
      e = sb.pop_front();
      n_cmp++;
      if (instr !== e.instr || instr_pc !== e.pc || instr_valid !== 1'b1) begin
        n_err++; $display("FAIL br_target got=%h@%h v=%b want=%h@%h v=1", instr, instr_pc, instr_valid, e.instr, e.pc);
      end
    end
    n_cmp++;
    if (instr !== 32'hA000_0010 || instr_pc !== 32'h40) begin
      n_err++; $display("FAIL br_target_const got=%h@%h want=a0000010@00000040", instr, instr_pc);
    end
  endtask

  task automatic test_branch_stall();
    drive(1'b1, 32'h43, 1'b1);
    n_cmp++;
    if (imem_addr !== 32'h40 || misaligned !== 1'b1 || instr_valid !== 1'b0) begin
      n_err++; $display("FAIL brst_mis got addr=%h mis=%b v=%b want addr=00000040 mis=1 v=0", imem_addr, misaligned, instr_valid);
    end
    drive(1'b0, 32'h0, 1'b1);
    n_cmp++;
    if (misaligned !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 32'h40) begin
      n_err++; $display("FAIL brst_pulse got mis=%b v=%b addr=%h want mis=0 v=0 addr=00000040", misaligned, instr_valid, imem_addr);
    end
    drive(1'b1, 32'h40, 1'b1);
    n_cmp++;
    if (misaligned !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 32'h40) begin
      n_err++; $display("FAIL brst_aligned got mis=%b v=%b addr=%h want mis=0 v=0 addr=00000040", misaligned, instr_valid, imem_addr);
    end
    drive(1'b0, 32'h0, 1'b0);
    if (sb.size() == 0) begin
      n_cmp++; n_err++; $display("FAIL brst_sb_empty got=empty want=entry");
    end else begin
      e = sb.pop_front();
      n_cmp++;
      if (instr !== e.instr || instr_pc !== e.pc || instr_valid !== 1'b1) begin
        n_err++; $display("FAIL brst_fetch got=%h@%h want=%h@%h", instr, instr_pc, e.instr, e.pc);
      end
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'h100, 1'b0);
    n_cmp++;
    if (instr_valid !== 1'b0 || imem_addr !== 32'h100) begin
      n_err++; $display("FAIL b2b_first got v=%b addr=%h want v=0 addr=00000100", instr_valid, imem_addr);
    end
    drive(1'b1, 32'h200, 1'b0);
    n_cmp++;
    if (instr_valid !== 1'b0 || imem_addr !== 32'h200) begin
      n_err++; $display("FAIL b2b_second got v=%b addr=%h want v=0 addr=00000200", instr_valid, imem_addr);
    end
    drive(1'b0, 32'h0, 1'b0);
    if (sb.size() == 0) begin
      n_cmp++; n_err++; $display("FAIL b2b_sb_empty got=empty want=entry");
    end else begin
      e = sb.pop_front();
      n_cmp++;
      if (instr !== e.instr || instr_pc !== e.pc || instr_valid !== 1'b1) begin
        n_err++; $display("FAIL b2b_fetch got=%h@%h want=%h@%h", instr, instr_pc, e.instr, e.pc);
      end
    end
  endtask

  task automatic test_wrap();
    drive(1'b1, 32'hFFFF_FFFC, 1'b0);
    n_cmp++;
    if (imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_addr got=%h want=fffffffc", imem_addr); end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'h0, 1'b0);
      if (sb.size() == 0) begin
        n_cmp++; n_err++; $display("FAIL wrap_sb_empty[%0d] got=empty want=entry", i);
      end else begin
        e = sb.pop_front();
        n_cmp++;
        if (instr !== e.instr || instr_pc !== e.pc || instr_valid !== 1'b1) begin
          n_err++; $display("FAIL wrap_fetch[%0d] got=%h@%h want=%h@%h", i, instr, instr_pc, e.instr, e.pc);
        end
      end
      n_cmp++;
      if (imem_addr !== m_pc) begin n_err++; $display("FAIL wrap_next[%0d] got=%h want=%h", i, imem_addr, m_pc); end
    end
    n_cmp++;
    if (instr_pc !== 32'h0 || imem_addr !== 32'h4) begin
      n_err++; $display("FAIL wrap_zero got pc=%h addr=%h want pc=00000000 addr=00000004", instr_pc, imem_addr);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0 || imem_addr !== 32'h0 || misaligned !== 1'b0) begin
      n_err++; $display("FAIL arst_clear got v=%b instr=%h pc=%h addr=%h want all 0", instr_valid, instr, instr_pc, imem_addr);
    end
    @(negedge clk);
    #1;
    reset = 1'b1;
    m_pc  = 32'h0;
    sb.delete();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'h0, 1'b0);
      if (sb.size() == 0) begin
        n_cmp++; n_err++; $display("FAIL arst_sb_empty[%0d] got=empty want=entry", i);
      end else begin
        e = sb.pop_front();
        n_cmp++;
        if (instr !== e.instr || instr_pc !== e.pc || instr_valid !== 1'b1) begin
          n_err++; $display("FAIL arst_restart[%0d] got=%h@%h want=%h@%h", i, instr, instr_pc, e.instr, e.pc);
        end
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL sb_leftover got=%0d want=0", sb.size()); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_branch_stall();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
